sgemm_row_tx: RTL and testbench

SGEMM_ROW_TX -- requirements
Module: sgemm_row_tx

---
 rtl/sgemm_row_tx.sv | 107 ++++++++++
 tb/tb_sgemm_row_tx.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sgemm_row_tx.sv
// Two-deep matrix buffer that streams each buffered 4x4 result matrix out
// one row per handshake, with a sticky flag for strobes that found it full.
module sgemm_row_tx #(
  parameter int ELEM_W = 32
) (
  input  logic                  ref_clk,
  input  logic                  rst,
  input  logic [16*ELEM_W-1:0]  res_in,
  input  logic                  res_valid,
  output logic [4*ELEM_W-1:0]   row_out,
  output logic                  row_valid,
  input  logic                  row_ready,
  output logic [1:0]            row_idx,
  output logic                  row_last,
  output logic [1:0]            occupancy,
  output logic                  overflow
);

  localparam int RW = 4 * ELEM_W;
  localparam int MW = 16 * ELEM_W;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t          state_q, state_d;
  logic [MW-1:0]   buf_q [2];
  logic [MW-1:0]   buf_d [2];
  logic            head_q, head_d;
  logic [1:0]      idx_q, idx_d;
  logic [1:0]      occ_q, occ_d;
  logic            ovf_q, ovf_d;

  logic            handshake;
  logic            pop;
  logic            capture;
  logic            wr_slot;
  logic [MW-1:0]   head_mat;

  // A full buffer can still take a strobe when its head leaves on the same edge;
  // the freed slot is then exactly the one being written.
  always_comb begin
    handshake = (state_q == SEND) && row_ready;
    pop       = handshake && (idx_q == 2'd3);
    capture   = res_valid && ((occ_q != 2'd2) || pop);
    wr_slot   = head_q ^ occ_q[0];

    buf_d = buf_q;
    if (capture) begin
      buf_d[wr_slot] = res_in;
    end

    head_d = pop ? ~head_q : head_q;

    idx_d = idx_q;
    if (handshake) begin
      idx_d = idx_q + 2'd1;
    end

    occ_d = occ_q;
    case ({capture, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase

    ovf_d = ovf_q | (res_valid & ~capture);

    state_d = state_q;
    case (state_q)
      IDLE:    if (capture) state_d = SEND;
      SEND:    if (occ_d == 2'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ref_clk) begin
    if (rst) begin
      state_q <= IDLE;
      buf_q   <= '{default: '0};
      head_q  <= 1'b0;
      idx_q   <= 2'd0;
      occ_q   <= 2'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      head_q  <= head_d;
      idx_q   <= idx_d;
      occ_q   <= occ_d;
      ovf_q   <= ovf_d;
    end
  end

  // Outputs depend only on registered state, never on res_in/res_valid.
  always_comb begin
    head_mat  = buf_q[head_q];
    row_valid = (state_q == SEND);
    row_out   = row_valid ? head_mat[RW*idx_q +: RW] : '0;
    row_idx   = idx_q;
    row_last  = row_valid && (idx_q == 2'd3);
    occupancy = occ_q;
    overflow  = ovf_q;
  end

endmodule

// File: tb/tb_sgemm_row_tx.sv
// Bench for sgemm_row_tx: a queue-based model checked every cycle, plus
// directed scenarios with literal expectations on rows, counts and flags.
module tb_sgemm_row_tx;

  localparam int ELEM_W = 32;
  localparam int RW = 4 * ELEM_W;
  localparam int MW = 16 * ELEM_W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [MW-1:0] resIn = '0;
  logic          resValid = 1'b0;
  logic          rowReady = 1'b0;
  logic [RW-1:0] rowOut;
  logic          rowValid;
  logic [1:0]    rowIdx;
  logic          rowLast;
  logic [1:0]    occupancy;
  logic          overflow;

  int checks = 0;
  int failures = 0;
  bit checkEn = 1'b0;

  logic [MW-1:0] modelQ[$];
  int            modelIdx = 0;
  bit            modelOvf = 1'b0;
  logic [RW-1:0] hsLog[$];

  always #5 clk = ~clk;

  sgemm_row_tx #(.ELEM_W(ELEM_W)) dut (
    .ref_clk   (clk),
    .rst       (rst),
    .res_in    (resIn),
    .res_valid (resValid),
    .row_out   (rowOut),
    .row_valid (rowValid),
    .row_ready (rowReady),
    .row_idx   (rowIdx),
    .row_last  (rowLast),
    .occupancy (occupancy),
    .overflow  (overflow)
  );

  task automatic checkOutput(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge, return mid-cycle.
  task automatic applyStimulus(input bit r, input bit v, input logic [MW-1:0] d, input bit rdy);
    @(posedge clk);
    #1;
    rst = r;
    resValid = v;
    resIn = d;
    rowReady = rdy;
    @(negedge clk);
  endtask

  function automatic logic [MW-1:0] makeMat(input logic [31:0] base);
    logic [MW-1:0] m;
    m = '0;
    for (int r = 0; r < 4; r++)
      for (int n = 0; n < 4; n++)
        m[RW*r + ELEM_W*n +: ELEM_W] = base + 32'(r*16 + n);
    return m;
  endfunction

  function automatic logic [RW-1:0] expRow(input logic [31:0] base, input int r);
    logic [31:0] b;
    b = base + 32'(r*16);
    return {b + 32'd3, b + 32'd2, b + 32'd1, b};
  endfunction

  // Behavioural model: FIFO of whole matrices plus the current row number.
  always @(posedge clk) begin
    bit hs, popM, acc;
    if (rst) begin
      modelQ.delete();
      modelIdx = 0;
      modelOvf = 1'b0;
    end else begin
      hs = (modelQ.size() > 0) && rowReady;
      popM = hs && (modelIdx == 3);
      acc = resValid && ((modelQ.size() < 2) || popM);
      if (resValid && !acc) modelOvf = 1'b1;
      if (hs) begin
        if (popM) begin
          void'(modelQ.pop_front());
          modelIdx = 0;
        end else begin
          modelIdx++;
        end
      end
      if (acc) modelQ.push_back(resIn);
    end
  end

  always @(negedge clk) begin
    logic [MW-1:0] hm;
    logic [RW-1:0] er;
    bit v;
    if (checkEn) begin
      v = modelQ.size() > 0;
      er = '0;
      if (v) begin
        hm = modelQ[0];
        er = hm[modelIdx*RW +: RW];
      end
      checkOutput("row_valid", RW'(rowValid), RW'(v));
      checkOutput("row_out", rowOut, er);
      checkOutput("row_idx", RW'(rowIdx), v ? RW'(modelIdx) : '0);
      checkOutput("row_last", RW'(rowLast), RW'(v && modelIdx == 3));
      checkOutput("occupancy", RW'(occupancy), RW'(modelQ.size()));
      checkOutput("overflow", RW'(overflow), RW'(modelOvf));
      if (!rst && rowValid && rowReady) hsLog.push_back(rowOut);
    end
  end

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    hsLog.delete();
  endtask

  initial begin
    logic [MW-1:0] matA;
    logic [RW-1:0] rowsA [4];

    rowsA[0] = 128'h00000000000000000000000000000000;
    rowsA[1] = 128'h11111111111111111111111111111111;
    rowsA[2] = 128'h22222222222222222222222222222222;
    rowsA[3] = 128'h33333333333333333333333333333333;
    matA = {rowsA[3], rowsA[2], rowsA[1], rowsA[0]};

    applyStimulus(1'b1, 1'b0, '0, 1'b1);
    applyStimulus(1'b1, 1'b1, makeMat(32'h9000_0000), 1'b1);
    checkEn = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkOutput("reset_valid", RW'(rowValid), '0);
    checkOutput("reset_row_out", rowOut, '0);
    checkOutput("reset_occ", RW'(occupancy), '0);
    checkOutput("reset_ovf", RW'(overflow), '0);

    // Single matrix, sink always ready
    applyStimulus(1'b0, 1'b1, matA, 1'b1);
    checkOutput("t1_idle_c0", RW'(rowValid), '0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      checkOutput("t1_row", rowOut, rowsA[k]);
      checkOutput("t1_idx", RW'(rowIdx), RW'(k));
      checkOutput("t1_last", RW'(rowLast), RW'(k == 3));
      checkOutput("t1_occ", RW'(occupancy), RW'(1));
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkOutput("t1_done_valid", RW'(rowValid), '0);
    checkOutput("t1_done_occ", RW'(occupancy), '0);

    // Backpressure with ready pattern 1,0,0,1
    doReset();
    applyStimulus(1'b0, 1'b1, makeMat(32'hB000_0000), 1'b1);
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(1'b0, 1'b0, '0, (k % 4 == 0) || (k % 4 == 3));
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkOutput("t2_hs_count", RW'(hsLog.size()), RW'(4));
    for (int r = 0; r < 4; r++)
      if (r < hsLog.size()) checkOutput("t2_hs_row", hsLog[r], expRow(32'hB000_0000, r));

    // Two back-to-back strobes
    doReset();
    applyStimulus(1'b0, 1'b1, makeMat(32'hC000_0000), 1'b1);
    applyStimulus(1'b0, 1'b1, makeMat(32'hD000_0000), 1'b1);
    for (int k = 2; k <= 10; k++) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      if (k == 2) checkOutput("t3_occ_peak", RW'(occupancy), RW'(2));
      checkOutput("t3_contig", RW'(rowValid), RW'(k <= 8));
    end
    checkOutput("t3_hs_count", RW'(hsLog.size()), RW'(8));
    for (int i = 0; i < 8; i++)
      if (i < hsLog.size())
        checkOutput("t3_hs_row", hsLog[i], expRow(i < 4 ? 32'hC000_0000 : 32'hD000_0000, i % 4));
    checkOutput("t3_ovf", RW'(overflow), '0);

    // Overflow: third strobe dropped while stalled
    doReset();
    applyStimulus(1'b0, 1'b1, makeMat(32'hE000_0000), 1'b0);
    applyStimulus(1'b0, 1'b1, makeMat(32'hF000_0000), 1'b0);
    applyStimulus(1'b0, 1'b1, makeMat(32'h7000_0000), 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkOutput("t4_ovf_set", RW'(overflow), RW'(1));
    checkOutput("t4_occ_full", RW'(occupancy), RW'(2));
    for (int k = 0; k < 12; k++) applyStimulus(1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkOutput("t4_hs_count", RW'(hsLog.size()), RW'(8));
    for (int i = 0; i < 8; i++)
      if (i < hsLog.size())
        checkOutput("t4_hs_row", hsLog[i], expRow(i < 4 ? 32'hE000_0000 : 32'hF000_0000, i % 4));
    checkOutput("t4_ovf_sticky", RW'(overflow), RW'(1));

    // Full buffer, strobe coincides with row_last handshake
    doReset();
    applyStimulus(1'b0, 1'b1, makeMat(32'h1000_0000), 1'b1);
    applyStimulus(1'b0, 1'b1, makeMat(32'h2000_0000), 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b1, makeMat(32'h3000_0000), 1'b1);
    checkOutput("t5_last_c4", RW'(rowLast), RW'(1));
    checkOutput("t5_occ_c4", RW'(occupancy), RW'(2));
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkOutput("t5_occ_c5", RW'(occupancy), RW'(2));
    checkOutput("t5_ovf", RW'(overflow), '0);
    for (int k = 6; k <= 14; k++) applyStimulus(1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkOutput("t5_hs_count", RW'(hsLog.size()), RW'(12));
    for (int i = 0; i < 12; i++)
      if (i < hsLog.size())
        checkOutput("t5_hs_row", hsLog[i], expRow(32'h1000_0000 + 32'h1000_0000 * 32'(i / 4), i % 4));

    // Reset mid-transmission, colliding with a strobe
    doReset();
    applyStimulus(1'b0, 1'b1, makeMat(32'h4000_0000), 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b1, 1'b1, makeMat(32'h5000_0000), 1'b1);
    checkOutput("t6_idx_before", RW'(rowIdx), RW'(2));
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkOutput("t6_valid_after", RW'(rowValid), '0);
    checkOutput("t6_occ_after", RW'(occupancy), '0);
    checkOutput("t6_ovf_after", RW'(overflow), '0);
    applyStimulus(1'b0, 1'b1, makeMat(32'h6000_0000), 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkOutput("t6_fresh_valid", RW'(rowValid), RW'(1));
    checkOutput("t6_fresh_idx", RW'(rowIdx), '0);
    checkOutput("t6_fresh_row", rowOut, expRow(32'h6000_0000, 0));
    applyStimulus(1'b0, 1'b0, '0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
